// File: rtl/bip_debug_unit_pkg.sv
// Shared constants for the BIP debug unit: FSM encodings, start command, counter sizing.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bip_debug_unit_pkg;

    // FSM encodings, kept as plain 2-bit constants so they match legacy dumps
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_SEND    = 2'd2;
    localparam logic [1:0] ST_WAIT_TX = 2'd3;

    // 'S' launches a program run
    localparam logic [7:0] CMD_START_DEF = 8'h53;

    // Width of a counter indexing n items, never below one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bip_debug_unit_if.sv
// Bundle of UART byte, CPU control and status signals around the debug unit.
// Latency: n/a (wiring only).
// Backpressure: tx side is paced by tx_done; rx side has none (bytes outside IDLE are dropped).
//   master: debug unit side (drives bip_enable, tx_start, tx_data, busy, timeout)
//   slave : environment side (drives rx_*, finish_program, result, tx_done)
interface bip_debug_unit_if #(
    parameter int DATA_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              finish_program;
    logic [DATA_W-1:0] result;
    logic              tx_done;
    logic              bip_enable;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              busy;
    logic              timeout;

    modport master (
        input  rx_data, rx_done, finish_program, result, tx_done,
        output bip_enable, tx_start, tx_data, busy, timeout
    );

    modport slave (
        output rx_data, rx_done, finish_program, result, tx_done,
        input  bip_enable, tx_start, tx_data, busy, timeout
    );
endinterface

// File: rtl/bip_debug_unit_watchdog.sv
// Run-time watchdog: counts enabled cycles and flags the last allowed cycle.
// Latency: o_expired is combinational on the count, high in the WDT_LIMIT-th enabled cycle.
// Backpressure: none.
//   i_clk, i_reset (async, active-low), i_clr (sync clear), i_en (count), o_expired
module bip_debug_unit_watchdog #(
    parameter int               WDT_W     = 16,
    parameter logic [WDT_W-1:0] WDT_LIMIT = '1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam logic [WDT_W-1:0] LAST = WDT_LIMIT - 1'b1;

    logic [WDT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Count starts at 0 in the first run cycle, so LAST marks exactly WDT_LIMIT cycles
    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/bip_debug_unit.sv
// Debug controller: start CPU on 'S', stop on halt edge or watchdog, stream result LSB-first.
// Latency: stop event -> first tx_start 1 cycle; tx_done -> next tx_start 1 cycle.
// Backpressure: one byte in flight, next byte waits for tx_done; rx ignored outside IDLE.
//   i_clk, i_reset (async, active-low), bus (bip_debug_unit_if.master)
module bip_debug_unit
    import bip_debug_unit_pkg::*;
#(
    parameter int               DATA_W    = 32,
    parameter logic [7:0]       CMD_START = CMD_START_DEF,
    parameter int               WDT_W     = 16,
    parameter logic [WDT_W-1:0] WDT_LIMIT = '1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    bip_debug_unit_if.master bus
);
    localparam int N_BYTES = DATA_W / 8;
    localparam int CNT_W   = cnt_width(N_BYTES);

    logic [1:0]        r_state;
    logic              r_fin_q;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic              r_bip_enable;
    logic              r_timeout;

    logic w_fin_rise;
    logic w_start;
    logic w_wdt_expired;

    // A halt level left high from the previous run produces no edge here
    assign w_fin_rise = bus.finish_program & ~r_fin_q;
    assign w_start    = (r_state == ST_IDLE) && bus.rx_done && (bus.rx_data == CMD_START);

    bip_debug_unit_watchdog #(
        .WDT_W     (WDT_W),
        .WDT_LIMIT (WDT_LIMIT)
    ) u_wdt (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (w_start),
        .i_en      (r_state == ST_RUN),
        .o_expired (w_wdt_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_fin_q      <= 1'b0;
            r_shreg      <= '0;
            r_byte_cnt   <= '0;
            r_bip_enable <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_fin_q <= bus.finish_program;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state      <= ST_RUN;
                        r_bip_enable <= 1'b1;
                        r_timeout    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Halt edge has priority over a coincident watchdog expiry
                    if (w_fin_rise) begin
                        r_shreg      <= bus.result;
                        r_byte_cnt   <= '0;
                        r_bip_enable <= 1'b0;
                        r_state      <= ST_SEND;
                    end else if (w_wdt_expired) begin
                        r_shreg      <= '1;
                        r_byte_cnt   <= '0;
                        r_timeout    <= 1'b1;
                        r_bip_enable <= 1'b0;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    // Exit is tested before the increment, so the byte counter never wraps
                    if (bus.tx_done) begin
                        if (r_byte_cnt == CNT_W'(N_BYTES - 1)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_shreg    <= r_shreg >> 8;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_state    <= ST_SEND;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.bip_enable = r_bip_enable;
    assign bus.tx_start   = (r_state == ST_SEND);
    assign bus.tx_data    = r_shreg[7:0];
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed bench: two DUTs share stimulus, one with the default watchdog and one with
// WDT_LIMIT=8; sel picks which one the monitor and checks observe.
module tb_bip_debug_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        fin = 1'b0;
    logic [31:0] result = 32'h0;
    logic        tx_done_auto = 1'b0;
    logic        tx_done_man = 1'b0;
    logic        tx_done;
    logic        sel = 1'b0;
    logic        tx_auto = 1'b0;

    always #5 clk = ~clk;
    assign tx_done = tx_done_auto | tx_done_man;

    bip_debug_unit_if #(.DATA_W(32)) bus_a ();
    bip_debug_unit_if #(.DATA_W(32)) bus_b ();

    assign bus_a.rx_data = rx_data;  assign bus_b.rx_data = rx_data;
    assign bus_a.rx_done = rx_done;  assign bus_b.rx_done = rx_done;
    assign bus_a.finish_program = fin;  assign bus_b.finish_program = fin;
    assign bus_a.result = result;    assign bus_b.result = result;
    assign bus_a.tx_done = tx_done;  assign bus_b.tx_done = tx_done;

    bip_debug_unit #(.DATA_W(32)) u_dut_a (.i_clk(clk), .i_reset(rst_n), .bus(bus_a));
    bip_debug_unit #(.DATA_W(32), .WDT_LIMIT(16'd8)) u_dut_b (.i_clk(clk), .i_reset(rst_n), .bus(bus_b));

    logic       m_en, m_start, m_busy, m_to;
    logic [7:0] m_data;
    assign m_en    = sel ? bus_b.bip_enable : bus_a.bip_enable;
    assign m_start = sel ? bus_b.tx_start   : bus_a.tx_start;
    assign m_busy  = sel ? bus_b.busy       : bus_a.busy;
    assign m_to    = sel ? bus_b.timeout    : bus_a.timeout;
    assign m_data  = sel ? bus_b.tx_data    : bus_a.tx_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;
    logic [7:0] tx_bytes[$];
    logic [7:0] done_data[$];
    int start_cyc[$];
    int done_cyc[$];

    // Monitor: cycle index, enable count, transmitted bytes and tx_done timing
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (m_en) en_cnt <= en_cnt + 1;
        if (m_start) begin
            tx_bytes.push_back(m_data);
            start_cyc.push_back(cyc + 1);
        end
        if (tx_done_auto) begin
            done_data.push_back(m_data);
            done_cyc.push_back(cyc + 1);
        end
    end

    // UART TX model: answers each tx_start with a tx_done two cycles later
    initial begin
        forever begin
            @(negedge clk);
            if (tx_auto && m_start && rst_n) begin
                repeat (2) @(posedge clk);
                #1 tx_done_auto = 1'b1;
                @(posedge clk);
                #1 tx_done_auto = 1'b0;
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!m_busy) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic test_reset;
        sel = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL reset_bip_enable: got %b want 0", m_en); end
        checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", m_start); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", m_data); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", m_busy); end
        checks++; if (m_to !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", m_to); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ignore_other_byte;
        sel = 1'b0;
        send_rx(8'h41);
        repeat (2) @(negedge clk);
        checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL ignore_41_enable: got %b want 0", m_en); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL ignore_41_busy: got %b want 0", m_busy); end
    endtask

    task automatic test_basic_run;
        logic [7:0] exp_b [4] = '{8'hAB, 8'h00, 8'h05, 8'h00};
        int nb, ns, nd, en0, k;
        bit ok;
        sel = 1'b0; tx_auto = 1'b1; fin = 1'b0; result = 32'h0005_00AB;
        nb = tx_bytes.size(); ns = start_cyc.size(); nd = done_cyc.size(); en0 = en_cnt;
        send_rx(8'h53);
        repeat (19) @(posedge clk);
        #1 fin = 1'b1; k = cyc;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_idle: busy stuck at %b want 0", m_busy); end
        checks++; if (en_cnt - en0 !== 20) begin errors++; $display("FAIL basic_enable_cycles: got %0d want 20", en_cnt - en0); end
        checks++; if (tx_bytes.size() - nb !== 4) begin errors++; $display("FAIL basic_byte_count: got %0d want 4", tx_bytes.size() - nb); end
        if (tx_bytes.size() - nb == 4 && done_cyc.size() - nd == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (tx_bytes[nb+i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, tx_bytes[nb+i], exp_b[i]); end
                checks++; if (done_data[nd+i] !== exp_b[i]) begin errors++; $display("FAIL basic_hold%0d: got %h want %h", i, done_data[nd+i], exp_b[i]); end
            end
            checks++; if (start_cyc[ns] !== k + 2) begin errors++; $display("FAIL basic_first_latency: got cycle %0d want %0d", start_cyc[ns], k + 2); end
            for (int i = 1; i < 4; i++) begin
                checks++; if (start_cyc[ns+i] - done_cyc[nd+i-1] !== 1) begin errors++; $display("FAIL basic_spacing%0d: got %0d want 1", i, start_cyc[ns+i] - done_cyc[nd+i-1]); end
            end
            checks++; if (cyc !== done_cyc[nd+3] + 1) begin errors++; $display("FAIL basic_busy_drop: got cycle %0d want %0d", cyc, done_cyc[nd+3] + 1); end
        end
        checks++; if (m_to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", m_to); end
        fin = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_timeout_run;
        int nb, en0;
        bit ok;
        sel = 1'b1; tx_auto = 1'b1; fin = 1'b0;
        nb = tx_bytes.size(); en0 = en_cnt;
        send_rx(8'h53);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wdt_idle: busy stuck at %b want 0", m_busy); end
        checks++; if (en_cnt - en0 !== 8) begin errors++; $display("FAIL wdt_run_cycles: got %0d want 8", en_cnt - en0); end
        checks++; if (tx_bytes.size() - nb !== 4) begin errors++; $display("FAIL wdt_byte_count: got %0d want 4", tx_bytes.size() - nb); end
        if (tx_bytes.size() - nb == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (tx_bytes[nb+i] !== 8'hFF) begin errors++; $display("FAIL wdt_byte%0d: got %h want ff", i, tx_bytes[nb+i]); end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_to !== 1'b1) begin errors++; $display("FAIL wdt_sticky: got %b want 1", m_to); end
        send_rx(8'h53);
        checks++; if (m_to !== 1'b0) begin errors++; $display("FAIL wdt_clear_on_start: got %b want 0", m_to); end
        checks++; if (m_en !== 1'b1) begin errors++; $display("FAIL wdt_restart_enable: got %b want 1", m_en); end
        wait_idle(200, ok);
        repeat (2) @(posedge clk);
    endtask

    task automatic test_held_finish;
        int nb, en0;
        bit ok;
        sel = 1'b1; tx_auto = 1'b1; fin = 1'b1; result = 32'h0001_0002;
        repeat (3) @(posedge clk);
        nb = tx_bytes.size(); en0 = en_cnt;
        send_rx(8'h53);
        wait_idle(200, ok);
        checks++; if (en_cnt - en0 !== 8) begin errors++; $display("FAIL held_run_cycles: got %0d want 8", en_cnt - en0); end
        checks++; if (m_to !== 1'b1) begin errors++; $display("FAIL held_timeout: got %b want 1", m_to); end
        checks++; if (tx_bytes.size() - nb !== 4 || tx_bytes[nb] !== 8'hFF) begin errors++; $display("FAIL held_bytes: got %0d bytes first %h want 4 bytes ff", tx_bytes.size() - nb, tx_bytes[nb]); end
        fin = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ignored_inputs;
        logic [7:0] exp_b [4] = '{8'hEF, 8'hBE, 8'h21, 8'h03};
        int nb, en0;
        bit ok;
        sel = 1'b1; tx_auto = 1'b1; fin = 1'b0; result = 32'h0321_BEEF;
        nb = tx_bytes.size(); en0 = en_cnt;
        send_rx(8'h53);
        @(posedge clk); #1 rx_data = 8'h53; rx_done = 1'b1;
        @(posedge clk); #1 rx_done = 1'b0; tx_done_man = 1'b1;
        @(posedge clk); #1 tx_done_man = 1'b0;
        checks++; if (m_en !== 1'b1 || m_busy !== 1'b1) begin errors++; $display("FAIL run_ignores_inputs: en=%b busy=%b want 1 1", m_en, m_busy); end
        repeat (4) @(posedge clk);
        #1 fin = 1'b1;
        @(posedge clk); #1 rx_data = 8'h53; rx_done = 1'b1;
        @(posedge clk); #1 rx_done = 1'b0;
        wait_idle(200, ok);
        checks++; if (en_cnt - en0 !== 8) begin errors++; $display("FAIL tie_run_cycles: got %0d want 8", en_cnt - en0); end
        checks++; if (m_to !== 1'b0) begin errors++; $display("FAIL tie_timeout: got %b want 0", m_to); end
        checks++; if (tx_bytes.size() - nb !== 4) begin errors++; $display("FAIL tie_byte_count: got %0d want 4", tx_bytes.size() - nb); end
        if (tx_bytes.size() - nb == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (tx_bytes[nb+i] !== exp_b[i]) begin errors++; $display("FAIL tie_byte%0d: got %h want %h", i, tx_bytes[nb+i], exp_b[i]); end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_en !== 1'b0 || m_busy !== 1'b0) begin errors++; $display("FAIL send_ignores_rx: en=%b busy=%b want 0 0", m_en, m_busy); end
        fin = 1'b0;
    endtask

    task automatic test_reset_mid_send;
        int nb, en0;
        bit ok, seen;
        sel = 1'b1; tx_auto = 1'b1; fin = 1'b0;
        nb = tx_bytes.size();
        send_rx(8'h53);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (tx_bytes.size() - nb >= 2) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_reach_byte2: got %0d bytes want 2", tx_bytes.size() - nb); end
        @(posedge clk); #1;
        checks++; if (m_busy !== 1'b1 || m_to !== 1'b1) begin errors++; $display("FAIL abort_pre_state: busy=%b timeout=%b want 1 1", m_busy, m_to); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_en !== 1'b0 || m_start !== 1'b0 || m_data !== 8'h00 || m_busy !== 1'b0 || m_to !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: en=%b start=%b data=%h busy=%b timeout=%b want all 0", m_en, m_start, m_data, m_busy, m_to);
        end
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        nb = tx_bytes.size(); en0 = en_cnt;
        send_rx(8'h53);
        wait_idle(200, ok);
        checks++; if (!ok || en_cnt - en0 !== 8) begin errors++; $display("FAIL abort_clean_run: ok=%b cycles=%0d want 1 8", ok, en_cnt - en0); end
        checks++; if (tx_bytes.size() - nb !== 4 || tx_bytes[nb] !== 8'hFF || tx_bytes[nb+3] !== 8'hFF) begin
            errors++; $display("FAIL abort_clean_bytes: got %0d bytes want 4 of ff", tx_bytes.size() - nb);
        end
    endtask

    initial begin
        test_reset();
        test_ignore_other_byte();
        test_basic_run();
        test_timeout_run();
        test_held_finish();
        test_ignored_inputs();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
